bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
Parametrised, multi-digit BCD-to-binary converter. It is the clocked successor to the 6-bit SN74184-style converter. It converts DIGITS packed BCD digits to a BIN_W-bit binary value using iterative reverse double-dabble: one shift-right and per-digit correction step per clock. It uses valid/ready handshakes on input and output, flags illegal BCD digits, and keeps the 74184-style active-low output enable (g_n).

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in (1..8).
- BIN_W, 14, binary output width. Must satisfy 2^BIN_W >= 10^DIGITS (e.g. DIGITS=2 -> 7, DIGITS=4 -> 14). Also sets the iteration count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- g_n  input  1  active-low output enable. When 1, bin_out reads all ones. Does not affect state.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  converter can accept (high only in IDLE).
- bcd_in  input  4*DIGITS  packed BCD; digit 0 = bits [3:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_W  binary result (masked by g_n).
- err  output  1  the held result came from an illegal BCD input.
- busy  output  1  high in SHIFT.

Behaviour:
- One clock, rst. Synchronous reset is active-high.
- States: IDLE, SHIFT, DONE. Reset forces IDLE. On reset: in_ready=1, out_valid=0, err=0, busy=0, internal result=0, counter=0. bin_out then reads 0 if g_n=0, all ones if g_n=1.
- Accept: in_valid & in_ready sampled at edge k (IDLE only).
  - If any nibble of bcd_in > 9: go to DONE, result=0, err=1. out_valid=1 after edge k (no iterations).
  - Otherwise: load scratch=bcd_in, result=0, counter=BIN_W, err=0, go to SHIFT.
- SHIFT, each edge:
  - {scratch,result} shifted right by 1, so scratch LSB enters result MSB.
  - Then each 4-bit digit of the new scratch that is >= 8 has 3 subtracted.
  - Counter decrements. When the counter reaches 0 (after the BIN_W-th iteration), go to DONE.
- Latency: out_valid is first high in the cycle after edge k+BIN_W (legal input), or after edge k+1 equivalent, i.e. the cycle after edge k (illegal input).
- DONE: out_valid=1. bin_out/err held stable until out_valid & out_ready, then go to IDLE on that edge. There is no overlap: in_ready=0 in SHIFT and DONE, and the next input is accepted no earlier than the cycle after the output handshake.
- in_valid asserted during SHIFT/DONE is ignored (not latched). bcd_in may change freely after acceptance.
- g_n is a purely combinational mask on bin_out only. out_valid, err and the handshake are unaffected. The result is not lost while g_n=1.
- rst asserted mid-SHIFT or in DONE aborts the conversion and returns to IDLE with reset values the next cycle. No partial result is ever presented.
- Arithmetic is unsigned. For the maximum input (all nines) the result is 10^DIGITS-1 and fits BIN_W by the parameter rule. Result bits above the value are 0.
- Counter width is ceil(log2(BIN_W+1)). No wrap is possible.

Test Plan:
- DIGITS=4, BIN_W=14, g_n=0:
  - bcd_in=16'h1234, out_ready=1 -> out_valid high 14 edges after accept, bin_out=14'h04D2, err=0, one-cycle out_valid, in_ready high the next cycle.
  - bcd_in=16'h9999 then 16'h0000, back-to-back -> bin_out=14'h270F, then 14'h0000, each 14-cycle latency. Second input accepted only after the first output handshake.
  - bcd_in=16'h12A4 -> err=1, bin_out=0, out_valid in the cycle after accept.
- Backpressure: out_ready held 0 for 10 cycles after the 16'h0042 result -> out_valid/bin_out=14'h002A stable throughout. in_ready=0 and in_valid pulses ignored. Release -> handshake, then IDLE.
- g_n=1 during DONE with result 14'h04D2 -> bin_out=14'h3FFF. Deassert g_n -> 14'h04D2 reappears, handshake unchanged.
- rst pulsed on the 5th SHIFT cycle of 16'h5678 -> next cycle in_ready=1, out_valid=0, busy=0, err=0. A new conversion of 16'h0001 gives 14'h0001.

Source files
------------

// File: rtl/bcd2bin_if.sv
// Handshake bundle for bcd2bin_seq: input BCD word, output binary result,
// status flags and the 74184-style active-low output enable.
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  g_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output g_n, in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  g_n, in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one shift plus
// per-digit correction per clock, valid/ready on both sides.

module bcd2bin_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic      clk,
  input  logic      rst,
  bcd2bin_if.slave  bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [DIGITS-1:0][3:0] bcd_d, scratch, shifted, fixed;
  logic [BIN_W-1:0]       result;
  logic [CNT_W-1:0]       cnt;
  logic                   err_q;
  logic                   illegal;

  assign bcd_d   = bus.bcd_in;
  assign shifted = scratch >> 1;

  // after the shift every digit that reached 8..15 was an odd-half carry: fold it back by 3
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd2bin_digit u_dig (.d(shifted[i]), .q(fixed[i]));
  end

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_d[i] > 4'd9) illegal = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = illegal ? DONE : SHIFT;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      scratch <= '0;
      result  <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.in_valid) begin
          result <= '0;
          err_q  <= illegal;
          if (!illegal) begin
            scratch <= bcd_d;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch <= fixed;
          result  <= {scratch[0][0], result[BIN_W-1:1]};
          cnt     <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out = bus.g_n ? '1 : result;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq (DIGITS=4, BIN_W=14); drives and samples on
// the falling edge, all expected values hand-computed.
module tb_bcd2bin_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd2bin_if #(.DIGITS(4), .BIN_W(14)) bus ();
  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic start(input logic [15:0] v);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 64) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 64) begin n_fail++; $display("FAIL start_ready: in_ready=%b never high, required 1", bus.in_ready); end
    bus.bcd_in   = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat = edges after the accepting edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.err, bus.busy} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: rdy/vld/err/busy=%b required 1000",
                         {bus.in_ready, bus.out_valid, bus.err, bus.busy});
    end
    n_checks++;
    if (bus.bin_out !== 14'h0000) begin n_fail++; $display("FAIL reset_bin: got %h required 0000", bus.bin_out); end
    bus.g_n = 1'b1; #1;
    n_checks++;
    if (bus.bin_out !== 14'h3FFF) begin n_fail++; $display("FAIL reset_gn: got %h required 3fff", bus.bin_out); end
    bus.g_n = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    bus.out_ready = 1'b1;
    start(16'h1234);
    n_checks++;
    if ({bus.busy, bus.in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL basic_busy: busy/in_ready=%b required 10", {bus.busy, bus.in_ready});
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 14) begin n_fail++; $display("FAIL basic_latency: got %0d required 14", lat); end
    n_checks++;
    if (bus.bin_out !== 14'h04D2 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL basic_value: got %h err %b required 04d2 err 0", bus.bin_out, bus.err);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL basic_after: out_valid/in_ready=%b required 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.out_ready = 1'b1;
    start(16'h9999);
    wait_valid(lat);
    n_checks++;
    if (lat !== 14 || bus.bin_out !== 14'h270F) begin
      n_fail++; $display("FAIL b2b_first: lat %0d val %h required 14 270f", lat, bus.bin_out);
    end
    // second word presented while first result is still being handed off
    bus.bcd_in   = 16'h0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_gap: vld/rdy/busy=%b required 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    n_checks++;
    if (lat !== 14 || bus.bin_out !== 14'h0000) begin
      n_fail++; $display("FAIL b2b_second: lat %0d val %h required 14 0000", lat, bus.bin_out);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int lat;
    bus.out_ready = 1'b1;
    start(16'h12A4);
    wait_valid(lat);
    n_checks++;
    if (lat !== 0 || bus.err !== 1'b1 || bus.bin_out !== 14'h0000) begin
      n_fail++; $display("FAIL illegal: lat %0d err %b val %h required 0 1 0000", lat, bus.err, bus.bin_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_idle: in_ready=%b required 1", bus.in_ready); end
  endtask

  task automatic test_backpressure;
    int lat;
    bus.out_ready = 1'b0;
    start(16'h0042);
    wait_valid(lat);
    n_checks++;
    if (lat !== 14 || bus.bin_out !== 14'h002A || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL bp_value: lat %0d val %h err %b required 14 002a 0", lat, bus.bin_out, bus.err);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.bcd_in   = 16'h0999;
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.bin_out !== 14'h002A) begin
        n_fail++; $display("FAIL bp_hold[%0d]: vld/rdy=%b val %h required 10 002a", i, {bus.out_valid, bus.in_ready}, bus.bin_out);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_fail++; $display("FAIL bp_release: vld/rdy/busy=%b required 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_gate;
    int lat;
    bus.out_ready = 1'b0;
    start(16'h1234);
    wait_valid(lat);
    bus.g_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.bin_out !== 14'h3FFF || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL gate_mask: val %h vld %b required 3fff 1", bus.bin_out, bus.out_valid);
    end
    bus.g_n = 1'b0; #1;
    n_checks++;
    if (bus.bin_out !== 14'h04D2 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL gate_unmask: val %h vld %b required 04d2 1", bus.bin_out, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL gate_hs: vld/rdy=%b required 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_abort;
    int lat;
    bus.out_ready = 1'b1;
    start(16'h5678);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.err} !== 4'b1000 || bus.bin_out !== 14'h0000) begin
      n_fail++; $display("FAIL abort_state: rdy/vld/busy/err=%b val %h required 1000 0000",
                         {bus.in_ready, bus.out_valid, bus.busy, bus.err}, bus.bin_out);
    end
    start(16'h0001);
    wait_valid(lat);
    n_checks++;
    if (lat !== 14 || bus.bin_out !== 14'h0001) begin
      n_fail++; $display("FAIL abort_next: lat %0d val %h required 14 0001", lat, bus.bin_out);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.g_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_gate();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
